// File: rtl/asrv32_pkg.sv
// Shared definitions for the ASRV32 writeback stage: one-hot opcode indices,
// load funct3 encodings and the writeback FSM state type.
package asrv32_pkg;

  localparam int unsigned OPCODE_WIDTH = 11;

  localparam int unsigned OP_RTYPE  = 0;
  localparam int unsigned OP_ITYPE  = 1;
  localparam int unsigned OP_LOAD   = 2;
  localparam int unsigned OP_STORE  = 3;
  localparam int unsigned OP_BRANCH = 4;
  localparam int unsigned OP_JAL    = 5;
  localparam int unsigned OP_JALR   = 6;
  localparam int unsigned OP_LUI    = 7;
  localparam int unsigned OP_AUIPC  = 8;
  localparam int unsigned OP_SYSTEM = 9;
  localparam int unsigned OP_FENCE  = 10;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/asrv32_load_extend.sv
// Load data alignment and sign/zero extension, selected by funct3 and the
// byte offset of the load address.
module asrv32_load_extend
  import asrv32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      addr_lsb_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] ext_o
);

  localparam logic [2:0] OFF_MASK = (XLEN == 64) ? 3'b111 : 3'b011;

  logic [2:0]  off;
  logic [5:0]  b_sh;
  logic [5:0]  h_sh;
  logic [5:0]  w_sh;
  logic [7:0]  b_data;
  logic [15:0] h_data;
  logic [31:0] w_data;

  // Offset bits beyond the datapath width are ignored
  assign off    = addr_lsb_i & OFF_MASK;
  assign b_sh   = {off, 3'b000};
  assign h_sh   = {off[2:1], 4'b0000};
  assign w_sh   = {off[2], 5'b00000};
  assign b_data = 8'(rdata_i >> b_sh);
  assign h_data = 16'(rdata_i >> h_sh);
  assign w_data = 32'(rdata_i >> w_sh);

  always_comb begin
    ext_o = rdata_i;
    case (funct3_i)
      F3_LB:   ext_o = XLEN'($signed(b_data));
      F3_LBU:  ext_o = XLEN'(b_data);
      F3_LH:   ext_o = XLEN'($signed(h_data));
      F3_LHU:  ext_o = XLEN'(h_data);
      F3_LW:   ext_o = XLEN'($signed(w_data));
      F3_LWU:  ext_o = (XLEN == 64) ? XLEN'(w_data) : rdata_i;
      default: ext_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/asrv32_writeback_unit.sv
// ASRV32 writeback stage: commits rd and next PC, waits for load data,
// flags misaligned control-flow targets and counts retired instructions.
module asrv32_writeback_unit
  import asrv32_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic [2:0]              i_funct3,
  input  logic [XLEN-1:0]         i_alu_result,
  input  logic [XLEN-1:0]         i_imm,
  input  logic [XLEN-1:0]         i_rs1_data,
  input  logic [2:0]              i_addr_lsb,
  input  logic                    i_mem_ack,
  input  logic [XLEN-1:0]         i_mem_rdata,
  input  logic [XLEN-1:0]         i_csr_rdata,
  input  logic                    i_go_to_trap,
  input  logic                    i_return_from_trap,
  input  logic [XLEN-1:0]         i_trap_address,
  input  logic [XLEN-1:0]         i_return_address,
  output logic [XLEN-1:0]         o_rd,
  output logic                    o_wr_rd_en,
  output logic [XLEN-1:0]         o_pc,
  output logic                    o_commit,
  output logic                    o_misaligned,
  output logic [XLEN-1:0]         o_bad_addr,
  output logic [63:0]             o_instret
);

  wb_state_e       state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [2:0]      lsb_q, lsb_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            commit_q, commit_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] bad_q, bad_d;
  logic [63:0]     instret_q;

  logic [XLEN-1:0] add_a;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] target;
  logic            is_ctrl;

  // Single adder shared by AUIPC/JAL/BRANCH (pc + imm) and JALR (rs1 + imm)
  assign add_a    = i_opcode[OP_JALR] ? i_rs1_data : pc_q;
  assign sum      = add_a + i_imm;
  assign pc_plus4 = pc_q + XLEN'(4);

  asrv32_load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3_i   (funct3_q),
    .addr_lsb_i (lsb_q),
    .rdata_i    (i_mem_rdata),
    .ext_o      (load_ext)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      funct3_q  <= 3'd0;
      lsb_q     <= 3'd0;
      rd_q      <= '0;
      wr_q      <= 1'b0;
      pc_q      <= PC_RESET;
      commit_q  <= 1'b0;
      mis_q     <= 1'b0;
      bad_q     <= '0;
      instret_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      lsb_q     <= lsb_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      pc_q      <= pc_d;
      commit_q  <= commit_d;
      mis_q     <= mis_d;
      bad_q     <= bad_d;
      instret_q <= instret_q + 64'(commit_d);
    end
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    lsb_d    = lsb_q;
    rd_d     = rd_q;
    wr_d     = 1'b0;
    pc_d     = pc_q;
    commit_d = 1'b0;
    mis_d    = 1'b0;
    bad_d    = bad_q;
    target   = pc_plus4;
    is_ctrl  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (i_go_to_trap) begin
            pc_d = i_trap_address;
          end else if (i_return_from_trap) begin
            pc_d = i_return_address;
          end else if (i_opcode[OP_LOAD]) begin
            state_d  = WAIT_MEM;
            funct3_d = i_funct3;
            lsb_d    = i_addr_lsb;
          end else begin
            wr_d = 1'b1;
            if (i_opcode[OP_RTYPE] || i_opcode[OP_ITYPE]) begin
              rd_d = i_alu_result;
            end else if (i_opcode[OP_LUI]) begin
              rd_d = i_imm;
            end else if (i_opcode[OP_AUIPC]) begin
              rd_d = sum;
            end else if (i_opcode[OP_SYSTEM]) begin
              rd_d = i_csr_rdata;
              wr_d = (i_funct3 != 3'd0);
            end else if (i_opcode[OP_JAL]) begin
              rd_d    = pc_plus4;
              target  = sum;
              is_ctrl = 1'b1;
            end else if (i_opcode[OP_JALR]) begin
              rd_d    = pc_plus4;
              target  = {sum[XLEN-1:1], 1'b0};
              is_ctrl = 1'b1;
            end else if (i_opcode[OP_BRANCH]) begin
              wr_d = 1'b0;
              if (i_alu_result[0]) begin
                target  = sum;
                is_ctrl = 1'b1;
              end
            end else begin
              wr_d = 1'b0;
            end

            // A misaligned target retires nothing and leaves rd/pc intact
            if (is_ctrl && (target[1:0] != 2'b00)) begin
              mis_d = 1'b1;
              bad_d = target;
              wr_d  = 1'b0;
              rd_d  = rd_q;
            end else begin
              pc_d     = target;
              commit_d = 1'b1;
            end
          end
        end
      end

      WAIT_MEM: begin
        if (i_go_to_trap) begin
          pc_d    = i_trap_address;
          state_d = IDLE;
        end else if (i_mem_ack) begin
          rd_d     = load_ext;
          wr_d     = 1'b1;
          pc_d     = pc_plus4;
          commit_d = 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_ready      = (state_q == IDLE);
  assign o_rd         = rd_q;
  assign o_wr_rd_en   = wr_q;
  assign o_pc         = pc_q;
  assign o_commit     = commit_q;
  assign o_misaligned = mis_q;
  assign o_bad_addr   = bad_q;
  assign o_instret    = instret_q;

endmodule

// File: tb/tb_asrv32_writeback_unit.sv
// Directed bench for asrv32_writeback_unit: a 32-bit instance driven from a
// vector table plus load/trap sequences, and a 64-bit instance for wide loads.
module tb_asrv32_writeback_unit;
  import asrv32_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 32-bit instance signals
  logic                    a_rst, a_valid, a_ready, a_ack, a_trap, a_ret;
  logic [OPCODE_WIDTH-1:0] a_opcode;
  logic [2:0]              a_funct3, a_lsb;
  logic [31:0]             a_alu, a_imm, a_rs1, a_rdata, a_csr, a_trap_addr, a_ret_addr;
  logic [31:0]             a_rd, a_pc, a_bad;
  logic                    a_wr, a_commit, a_mis;
  logic [63:0]             a_instret;

  // 64-bit instance signals
  logic                    b_rst, b_valid, b_ready, b_ack;
  logic [OPCODE_WIDTH-1:0] b_opcode;
  logic [2:0]              b_funct3, b_lsb;
  logic [63:0]             b_rdata, b_rd, b_pc, b_bad;
  logic                    b_wr, b_commit, b_mis;
  logic [63:0]             b_instret;

  asrv32_writeback_unit #(.XLEN(32), .PC_RESET(32'h100)) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_valid(a_valid), .o_ready(a_ready),
    .i_opcode(a_opcode), .i_funct3(a_funct3), .i_alu_result(a_alu),
    .i_imm(a_imm), .i_rs1_data(a_rs1), .i_addr_lsb(a_lsb),
    .i_mem_ack(a_ack), .i_mem_rdata(a_rdata), .i_csr_rdata(a_csr),
    .i_go_to_trap(a_trap), .i_return_from_trap(a_ret),
    .i_trap_address(a_trap_addr), .i_return_address(a_ret_addr),
    .o_rd(a_rd), .o_wr_rd_en(a_wr), .o_pc(a_pc), .o_commit(a_commit),
    .o_misaligned(a_mis), .o_bad_addr(a_bad), .o_instret(a_instret)
  );

  asrv32_writeback_unit #(.XLEN(64), .PC_RESET(64'h0)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_valid(b_valid), .o_ready(b_ready),
    .i_opcode(b_opcode), .i_funct3(b_funct3), .i_alu_result(64'h0),
    .i_imm(64'h0), .i_rs1_data(64'h0), .i_addr_lsb(b_lsb),
    .i_mem_ack(b_ack), .i_mem_rdata(b_rdata), .i_csr_rdata(64'h0),
    .i_go_to_trap(1'b0), .i_return_from_trap(1'b0),
    .i_trap_address(64'h0), .i_return_address(64'h0),
    .o_rd(b_rd), .o_wr_rd_en(b_wr), .o_pc(b_pc), .o_commit(b_commit),
    .o_misaligned(b_mis), .o_bad_addr(b_bad), .o_instret(b_instret)
  );

  typedef struct {
    string       name;
    logic [31:0] pc0;
    int          op;
    logic [2:0]  f3;
    logic [31:0] alu, imm, rs1, csr;
    logic        exp_wr, exp_commit, exp_mis;
    logic [31:0] exp_rd, exp_pc, exp_bad;
  } vec_t;

  vec_t        vecs[14];
  logic [63:0] exp_instret = 64'd0;

  function automatic logic [OPCODE_WIDTH-1:0] onehot(input int idx);
    return OPCODE_WIDTH'(1) << idx;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Present the current inputs for one accept edge, then withdraw them
  task automatic pulse_a();
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    a_trap  = 1'b0;
    a_ret   = 1'b0;
  endtask

  task automatic set_pc_a(input logic [31:0] addr);
    a_trap      = 1'b1;
    a_trap_addr = addr;
    pulse_a();
    chk("trap_pc", 64'(a_pc), 64'(addr));
    chk("trap_nocommit", 64'(a_commit), 64'd0);
  endtask

  // Load on the 32-bit instance with ack `lat` cycles after accept; a
  // competing ITYPE is held on i_valid while busy and must be ignored.
  task automatic load_a(input string nm, input logic [2:0] f3, input logic [2:0] lsb,
                        input logic [31:0] rdata, input int lat, input logic [31:0] exp);
    set_pc_a(32'h500);
    a_opcode = onehot(OP_LOAD); a_funct3 = f3; a_lsb = lsb; a_rdata = rdata;
    pulse_a();
    a_opcode = onehot(OP_ITYPE); a_alu = 32'h999; a_valid = 1'b1;
    for (int i = 0; i < lat; i++) begin
      chk({nm, "_busy"}, 64'(a_ready), 64'd0);
      chk({nm, "_nowr"}, 64'(a_wr), 64'd0);
      if (i == lat - 1) a_ack = 1'b1;
      @(posedge clk); #1;
    end
    a_ack = 1'b0; a_valid = 1'b0;
    exp_instret += 64'd1;
    chk({nm, "_rd"}, 64'(a_rd), 64'(exp));
    chk({nm, "_wr"}, 64'(a_wr), 64'd1);
    chk({nm, "_pc"}, 64'(a_pc), 64'h504);
    chk({nm, "_instret"}, a_instret, exp_instret);
    chk({nm, "_ready"}, 64'(a_ready), 64'd1);
  endtask

  task automatic load_b(input string nm, input logic [2:0] f3, input logic [2:0] lsb,
                        input logic [63:0] rdata, input logic [63:0] exp,
                        input logic [63:0] exp_pc, input logic [63:0] exp_ir);
    b_opcode = onehot(OP_LOAD); b_funct3 = f3; b_lsb = lsb; b_rdata = rdata;
    b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0; b_ack = 1'b1;
    @(posedge clk); #1;
    b_ack = 1'b0;
    chk({nm, "_rd"}, b_rd, exp);
    chk({nm, "_pc"}, b_pc, exp_pc);
    chk({nm, "_instret"}, b_instret, exp_ir);
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_valid = 1'b0; a_ack = 1'b0; a_trap = 1'b0; a_ret = 1'b0;
    a_opcode = '0; a_funct3 = 3'd0; a_lsb = 3'd0;
    a_alu = '0; a_imm = '0; a_rs1 = '0; a_rdata = '0; a_csr = '0;
    a_trap_addr = '0; a_ret_addr = '0;
    b_valid = 1'b0; b_ack = 1'b0; b_opcode = '0; b_funct3 = 3'd0; b_lsb = 3'd0; b_rdata = '0;

    //        name        pc0       op         f3    alu           imm           rs1           csr          wr  cm  mis  rd            pc            bad
    vecs[0]  = '{"itype",  32'h100, OP_ITYPE,  3'd0, 32'h55,       32'h0,        32'h0,        32'h0,       1, 1, 0, 32'h55,       32'h104,      32'h0};
    vecs[1]  = '{"rtype",  32'h100, OP_RTYPE,  3'd0, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,       1, 1, 0, 32'hDEADBEEF, 32'h104,      32'h0};
    vecs[2]  = '{"lui",    32'h300, OP_LUI,    3'd0, 32'h0,        32'h12345000, 32'h0,        32'h0,       1, 1, 0, 32'h12345000, 32'h304,      32'h0};
    vecs[3]  = '{"auipc",  32'h300, OP_AUIPC,  3'd0, 32'h0,        32'h1000,     32'h0,        32'h0,       1, 1, 0, 32'h1300,     32'h304,      32'h0};
    vecs[4]  = '{"csrrs",  32'h400, OP_SYSTEM, 3'd2, 32'h0,        32'h0,        32'h0,        32'hCAFE,    1, 1, 0, 32'hCAFE,     32'h404,      32'h0};
    vecs[5]  = '{"ecall",  32'h400, OP_SYSTEM, 3'd0, 32'h0,        32'h0,        32'h0,        32'h77,      0, 1, 0, 32'h0,        32'h404,      32'h0};
    vecs[6]  = '{"jalr",   32'h200, OP_JALR,   3'd0, 32'h0,        32'h0,        32'h1001,     32'h0,       1, 1, 0, 32'h204,      32'h1000,     32'h0};
    vecs[7]  = '{"jal_mis",32'h200, OP_JAL,    3'd0, 32'h0,        32'h6,        32'h0,        32'h0,       0, 0, 1, 32'h0,        32'h200,      32'h206};
    vecs[8]  = '{"jal",    32'h200, OP_JAL,    3'd0, 32'h0,        32'h20,       32'h0,        32'h0,       1, 1, 0, 32'h204,      32'h220,      32'h0};
    vecs[9]  = '{"br_nt",  32'h10,  OP_BRANCH, 3'd0, 32'h0,        32'h40,       32'h0,        32'h0,       0, 1, 0, 32'h0,        32'h14,       32'h0};
    vecs[10] = '{"br_tk",  32'h10,  OP_BRANCH, 3'd0, 32'h1,        32'hFFFFFFF0, 32'h0,        32'h0,       0, 1, 0, 32'h0,        32'h0,        32'h0};
    vecs[11] = '{"br_mis", 32'h10,  OP_BRANCH, 3'd0, 32'h1,        32'h2,        32'h0,        32'h0,       0, 0, 1, 32'h0,        32'h10,       32'h12};
    vecs[12] = '{"store",  32'h10,  OP_STORE,  3'd2, 32'h1234,     32'h8,        32'h0,        32'h0,       0, 1, 0, 32'h0,        32'h14,       32'h0};
    vecs[13] = '{"jalr_mis",32'h80, OP_JALR,   3'd0, 32'h0,        32'h2,        32'h100,      32'h0,       0, 0, 1, 32'h0,        32'h80,       32'h102};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc",      64'(a_pc), 64'h100);
    chk("rst_instret", a_instret, 64'd0);
    chk("rst_rd",      64'(a_rd), 64'd0);
    chk("rst_wr",      64'(a_wr), 64'd0);
    chk("rst_commit",  64'(a_commit), 64'd0);
    chk("rst_mis",     64'(a_mis), 64'd0);
    chk("rst_bad",     64'(a_bad), 64'd0);
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    chk("rst_ready",   64'(a_ready), 64'd1);
    @(posedge clk); #1;

    foreach (vecs[k]) begin
      set_pc_a(vecs[k].pc0);
      a_opcode = onehot(vecs[k].op); a_funct3 = vecs[k].f3;
      a_alu = vecs[k].alu; a_imm = vecs[k].imm; a_rs1 = vecs[k].rs1; a_csr = vecs[k].csr;
      pulse_a();
      if (vecs[k].exp_commit) exp_instret += 64'd1;
      chk({vecs[k].name, "_wr"},      64'(a_wr),     64'(vecs[k].exp_wr));
      chk({vecs[k].name, "_commit"},  64'(a_commit), 64'(vecs[k].exp_commit));
      chk({vecs[k].name, "_mis"},     64'(a_mis),    64'(vecs[k].exp_mis));
      chk({vecs[k].name, "_pc"},      64'(a_pc),     64'(vecs[k].exp_pc));
      chk({vecs[k].name, "_instret"}, a_instret,     exp_instret);
      if (vecs[k].exp_wr)  chk({vecs[k].name, "_rd"},  64'(a_rd),  64'(vecs[k].exp_rd));
      if (vecs[k].exp_mis) chk({vecs[k].name, "_bad"}, 64'(a_bad), 64'(vecs[k].exp_bad));
      @(posedge clk); #1;
      chk({vecs[k].name, "_pulse_end"}, 64'({a_wr, a_commit, a_mis}), 64'd0);
    end

    // MRET redirect
    a_ret = 1'b1; a_ret_addr = 32'h7F0;
    pulse_a();
    chk("mret_pc", 64'(a_pc), 64'h7F0);
    chk("mret_nocommit", 64'(a_commit), 64'd0);

    load_a("lb",  F3_LB,  3'd3, 32'h80FFFFFF, 2, 32'hFFFFFF80);
    load_a("lbu", F3_LBU, 3'd3, 32'h80FFFFFF, 2, 32'h00000080);
    load_a("lh",  F3_LH,  3'd2, 32'h80011234, 1, 32'hFFFF8001);
    load_a("lhu", F3_LHU, 3'd2, 32'h80011234, 1, 32'h00008001);
    load_a("lw",  F3_LW,  3'd0, 32'h12345678, 3, 32'h12345678);
    load_a("raw", 3'd7,   3'd1, 32'hA5A5_0F0F, 1, 32'hA5A5_0F0F);

    // Trap and ack in the same WAIT_MEM cycle: trap wins
    set_pc_a(32'h600);
    a_opcode = onehot(OP_LOAD); a_funct3 = F3_LW; a_lsb = 3'd0; a_rdata = 32'h1111;
    pulse_a();
    a_trap = 1'b1; a_trap_addr = 32'h40; a_ack = 1'b1;
    @(posedge clk); #1;
    a_trap = 1'b0; a_ack = 1'b0;
    chk("ldtrap_pc",      64'(a_pc), 64'h40);
    chk("ldtrap_wr",      64'(a_wr), 64'd0);
    chk("ldtrap_commit",  64'(a_commit), 64'd0);
    chk("ldtrap_ready",   64'(a_ready), 64'd1);
    chk("ldtrap_instret", a_instret, exp_instret);

    // 64-bit loads
    load_b("lwu64", F3_LWU, 3'd4, 64'hDEADBEEF_00000000, 64'h00000000_DEADBEEF, 64'h4, 64'd1);
    load_b("lw64",  F3_LW,  3'd4, 64'h80000000_00000000, 64'hFFFFFFFF_80000000, 64'h8, 64'd2);
    load_b("ld64",  F3_LD,  3'd0, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF, 64'hC, 64'd3);
    load_b("lb64",  F3_LB,  3'd7, 64'h80000000_00000000, 64'hFFFFFFFF_FFFFFF80, 64'h10, 64'd4);

    // Reset asserted while a load is pending
    b_opcode = onehot(OP_LOAD); b_funct3 = F3_LW; b_lsb = 3'd0; b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    chk("b_wait_ready", 64'(b_ready), 64'd0);
    b_rst = 1'b1;
    #1;
    chk("b_rst_pc",      b_pc, 64'h0);
    chk("b_rst_rd",      b_rd, 64'h0);
    chk("b_rst_instret", b_instret, 64'd0);
    chk("b_rst_flags",   64'({b_wr, b_commit, b_mis}), 64'd0);
    chk("b_rst_bad",     b_bad, 64'h0);
    chk("b_rst_ready",   64'(b_ready), 64'd1);
    @(posedge clk); #1;
    b_rst = 1'b0; b_ack = 1'b1;
    @(posedge clk); #1;
    b_ack = 1'b0;
    chk("b_drop_wr", 64'(b_wr), 64'd0);
    chk("b_drop_pc", b_pc, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/asrv32_writeback_unit.md
# asrv32_writeback_unit

Parametrised next-generation writeback stage for the ASRV32 core. It sits between execute/memory and the register file/fetch, and accepts one instruction at a time over a valid/ready handshake. It waits for a load response when the instruction is a load, and aligns and sign- or zero-extends the load data in the stage. It commits rd and the next PC, flags misaligned control-flow targets, and counts retired instructions.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values are 32 and 64.
- PC_RESET, 0: o_pc value on reset.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  execute presents an instruction.
- o_ready  out  1  stage can accept; equals (state == IDLE).
- i_opcode  in  OPCODE_WIDTH  one-hot opcode, same encoding as the core decoder.
- i_funct3  in  3  function field.
- i_alu_result  in  XLEN  ALU output; bit 0 is the branch-taken flag.
- i_imm  in  XLEN  immediate.
- i_rs1_data  in  XLEN  rs1 value.
- i_addr_lsb  in  3  low bits of the load address (byte offset).
- i_mem_ack  in  1  load data valid.
- i_mem_rdata  in  XLEN  raw load word.
- i_csr_rdata  in  XLEN  CSR read value.
- i_go_to_trap  in  1  trap request.
- i_return_from_trap  in  1  MRET request.
- i_trap_address  in  XLEN  trap target (MTVEC).
- i_return_address  in  XLEN  MRET target (MEPC).
- o_rd  out  XLEN  writeback data.
- o_wr_rd_en  out  1  one-cycle write strobe.
- o_pc  out  XLEN  current PC.
- o_commit  out  1  one-cycle retire pulse.
- o_misaligned  out  1  one-cycle misaligned-target exception pulse.
- o_bad_addr  out  XLEN  offending target; valid while o_misaligned is high.
- o_instret  out  64  count of retired instructions.

## Operation
FSM states are IDLE and WAIT_MEM.

IDLE, on i_valid && o_ready (accept):
- i_go_to_trap is asserted: o_pc <= i_trap_address. No write, no commit. Stay in IDLE.
- Otherwise i_return_from_trap is asserted: o_pc <= i_return_address. No write, no commit. Stay in IDLE.
- Otherwise the opcode is LOAD: go to WAIT_MEM and latch funct3 and addr_lsb. No output change.
- Otherwise, compute the result and commit:
  - RTYPE/ITYPE: rd = alu_result.
  - LUI: rd = imm.
  - AUIPC: rd = pc + imm.
  - SYSTEM with funct3 != 0: rd = csr_rdata.
  - JAL: rd = pc + 4, target = pc + imm.
  - JALR: rd = pc + 4, target = (rs1 + imm) & ~1.
  - BRANCH: target = pc + imm if alu_result[0] is set, else pc + 4.
  - Write is disabled for BRANCH, STORE, and SYSTEM with funct3 == 0.
  - All other opcodes: pc + 4.

Misaligned target:
- Applies when a JAL/JALR/taken-BRANCH target has bits [1:0] != 0.
- Response: o_misaligned pulses, o_bad_addr <= target, o_pc unchanged.
- No write and no commit.

WAIT_MEM:
- i_go_to_trap aborts the load: o_pc <= i_trap_address, no write, return to IDLE. Trap has priority over a simultaneous i_mem_ack.
- On i_mem_ack: rd = extended data, write, o_pc += 4, commit, return to IDLE.

Load extension, by latched funct3 and byte offset:
- LB (0) / LBU (4): byte at offset × 8, sign- or zero-extended.
- LH (1) / LHU (5): halfword at offset[2:1] × 16.
- LW (2): word at offset[2] × 32 when XLEN = 64, sign-extended.
- LWU (6) and LD (3): legal only when XLEN = 64.
- Any other funct3: the raw word is passed through unchanged.

Retire counting: o_instret increments by 1 on every o_commit and wraps at 2^64.

## Timing
Reset values:
- o_rd = 0, o_wr_rd_en = 0, o_pc = PC_RESET.
- o_commit = 0, o_misaligned = 0, o_bad_addr = 0, o_instret = 0.
- State = IDLE, so o_ready = 1 once reset is released.

Latency:
- Non-load: o_rd, o_wr_rd_en, o_pc and o_commit update on the accept edge and are visible the following cycle.
- Load: i_mem_ack is only sampled in WAIT_MEM, so the minimum is accept + 1 cycle. Results update on the ack edge.

Pulse and hold rules:
- o_wr_rd_en, o_commit and o_misaligned are single-cycle pulses. They are 0 in every cycle without a qualifying event.
- o_rd holds its last value.

Handshake and reset rules:
- i_valid while o_ready = 0 is ignored; the upstream holds the instruction.
- i_rst asserted mid-WAIT_MEM immediately forces the reset values. The pending load is dropped.

## Structure
Package asrv32_pkg holds:
- opcode bit indices and OPCODE_WIDTH;
- load funct3 encodings (LB, LH, LW, LD, LBU, LHU, LWU);
- the FSM state enum.

Sub-module asrv32_load_extend (combinational; inputs funct3, addr_lsb, rdata; output extended XLEN data) holds the alignment and extension mux. A single shared adder computes pc + imm and rs1 + imm.

## Test plan
- Reset with PC_RESET = 0x100: o_pc = 0x100, o_instret = 0, o_ready = 1. Then ITYPE with alu_result = 0x55 → next cycle o_rd = 0x55, o_wr_rd_en = 1, o_pc = 0x104, o_instret = 1.
- LB with addr_lsb = 3, rdata = 0x80FF_FFFF, i_mem_ack 2 cycles after accept → o_ready = 0 for 2 cycles, then o_rd = 0xFFFF_FF80. LBU under the same conditions → 0x0000_0080.
- JALR at pc = 0x200 with rs1 = 0x1001, imm = 0 → o_rd = 0x204, o_pc = 0x1000. JAL with imm = 0x6 → o_misaligned = 1, o_bad_addr = 0x206, o_pc stays 0x200, no write, o_instret unchanged.
- Load in WAIT_MEM with i_go_to_trap and i_mem_ack asserted in the same cycle, trap_address = 0x40 → o_pc = 0x40, o_wr_rd_en = 0, no commit.
- Not-taken branch (alu_result = 0) at pc = 0x10 → o_pc = 0x14, o_wr_rd_en = 0, o_commit = 1. SYSTEM with funct3 = 0 (ECALL path) → no write.
- XLEN = 64: LWU with addr_lsb = 4, rdata = 0xDEAD_BEEF_0000_0000 → o_rd = 0x0000_0000_DEAD_BEEF. i_rst pulsed mid-WAIT_MEM → all outputs return to their reset values.
